// File: rtl/sec_lock_pipe.sv
// sec_lock_pipe
//   Two-stage streaming single-error-correcting decoder with a key-gated
//   output mask. Data bit i lives at code position p_i (the i-th integer >= 3
//   that is not a power of two); check bit j lives at position 2^j. Decoded
//   words are XORed with a mask derived from the committed key, so the output
//   is only meaningful once the correct key has been shifted in. Repeated
//   wrong keys lead to a sticky lockout that forces an all-ones mask.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     input handshake
//   in_data, in_chk       received data word and check bits
//   out_valid/out_ready   output handshake
//   out_data              corrected data XOR lock mask
//   out_syn               syndrome of the word
//   out_corr, out_unc     single error corrected / syndrome not decodable
//   key_shift, key_bit    serial key port, MSB first
//   unlocked, lockout     key status (registered)
module sec_lock_pipe #(
  parameter int              DATA_W    = 32,
  parameter int              CHK_W     = 8,
  parameter int              KEY_W     = 16,
  parameter logic [KEY_W-1:0] KEY_VALUE = 16'hA5C3,
  parameter int              MAX_FAIL  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_syn,
  output logic              out_corr,
  output logic              out_unc,
  input  logic              key_shift,
  input  logic              key_bit,
  output logic              unlocked,
  output logic              lockout
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam logic [CNT_W-1:0]  KEY_W_C    = CNT_W'(KEY_W);
  localparam logic [FAIL_W-1:0] MAX_FAIL_C = FAIL_W'(MAX_FAIL);

  // Code position of data bit idx: skip 1, 2 and every other power of two.
  function automatic logic [CHK_W-1:0] pos_of(input int idx);
    int               cnt;
    logic [CHK_W-1:0] p;
    cnt = 0;
    p   = '0;
    for (int n = 3; n < 3 + DATA_W + CHK_W + 1; n++) begin
      if ((n & (n - 1)) != 0) begin
        if (cnt == idx) p = n[CHK_W-1:0];
        cnt++;
      end
    end
    return p;
  endfunction

  // XOR of the positions of all set data bits, folded with the check bits.
  function automatic logic [CHK_W-1:0] syndrome(input logic [DATA_W-1:0] d,
                                                input logic [CHK_W-1:0]  c);
    logic [CHK_W-1:0] s;
    s = c;
    for (int i = 0; i < DATA_W; i++) begin
      if (d[i]) s = s ^ pos_of(i);
    end
    return s;
  endfunction

  // Key difference repeated from the LSB across the word; all ones in lockout.
  function automatic logic [DATA_W-1:0] lock_mask(input logic [KEY_W-1:0] key,
                                                  input logic             lo);
    logic [KEY_W-1:0]  x;
    logic [DATA_W-1:0] m;
    x = key ^ KEY_VALUE;
    for (int i = 0; i < DATA_W; i++) begin
      m[i] = lo | x[i % KEY_W];
    end
    return m;
  endfunction

  // ---------------------------------------------------------------------------
  // Key FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {LOCKED, SHIFT, UNLOCKED, LOCKOUT} key_state_t;

  key_state_t        state;
  logic [KEY_W-1:0]  key_reg;
  logic [KEY_W-1:0]  shadow;
  logic [CNT_W-1:0]  bit_cnt;
  logic [FAIL_W-1:0] fail_cnt;

  logic [KEY_W-1:0]  next_shadow;
  logic [CNT_W-1:0]  next_cnt;
  logic [FAIL_W-1:0] next_fail;

  always_comb begin
    next_shadow = (shadow << 1) | KEY_W'(key_bit);
    // A shift outside SHIFT starts a fresh key, so counting restarts at one.
    next_cnt    = ((state == SHIFT) ? bit_cnt : '0) + CNT_W'(1);
    next_fail   = fail_cnt + FAIL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= LOCKED;
      key_reg  <= '0;
      shadow   <= '0;
      bit_cnt  <= '0;
      fail_cnt <= '0;
      unlocked <= (KEY_VALUE == '0);
      lockout  <= 1'b0;
    end else if (key_shift && state != LOCKOUT) begin
      shadow <= next_shadow;
      if (next_cnt == KEY_W_C) begin
        // Commit: key_reg takes the complete key on the same edge as the last bit.
        key_reg <= next_shadow;
        bit_cnt <= '0;
        if (next_shadow == KEY_VALUE) begin
          state    <= UNLOCKED;
          fail_cnt <= '0;
          unlocked <= 1'b1;
        end else if (next_fail >= MAX_FAIL_C) begin
          state    <= LOCKOUT;
          fail_cnt <= next_fail;
          unlocked <= 1'b0;
          lockout  <= 1'b1;
        end else begin
          state    <= LOCKED;
          fail_cnt <= next_fail;
          unlocked <= 1'b0;
        end
      end else begin
        // key_reg is untouched while shifting, so the unlock status persists.
        state   <= SHIFT;
        bit_cnt <= next_cnt;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline control
  // ---------------------------------------------------------------------------
  logic vld_p1, vld_p2;
  logic ready1, ready2;

  assign ready2    = !vld_p2 || out_ready;
  assign ready1    = !vld_p1 || ready2;
  assign in_ready  = ready1;
  assign out_valid = vld_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ready1) vld_p1 <= in_valid;
      if (ready2) vld_p2 <= vld_p1;
    end
  end

  // --- stage 1: capture word and syndrome ---
  logic [DATA_W-1:0] data_p1;
  logic [CHK_W-1:0]  syn_p1;

  always_ff @(posedge clk) begin
    if (in_valid && ready1) begin
      data_p1 <= in_data;
      syn_p1  <= syndrome(in_data, in_chk);
    end
  end

  // Decode from stage-1 registers.
  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_unc;
  logic              hit;
  logic              pow2;

  always_comb begin
    dec_data = data_p1;
    hit      = 1'b0;
    for (int k = 0; k < DATA_W; k++) begin
      if (syn_p1 == pos_of(k)) begin
        dec_data[k] = ~data_p1[k];
        hit         = 1'b1;
      end
    end
    pow2     = (syn_p1 != '0) && ((syn_p1 & (syn_p1 - CHK_W'(1))) == '0);
    dec_corr = (syn_p1 != '0) && (hit || pow2);
    dec_unc  = (syn_p1 != '0) && !(hit || pow2);
  end

  // --- stage 2: masked, decoded output ---
  // The mask uses key_reg as it stands before this edge, so a commit on the
  // same edge only affects later words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_syn  <= '0;
      out_corr <= 1'b0;
      out_unc  <= 1'b0;
    end else if (vld_p1 && ready2) begin
      out_data <= dec_data ^ lock_mask(key_reg, lockout);
      out_syn  <= syn_p1;
      out_corr <= dec_corr;
      out_unc  <= dec_unc;
    end
  end

endmodule

// File: tb/tb_sec_lock_pipe.sv
// Directed testbench for sec_lock_pipe with hand-computed expectations.
module tb_sec_lock_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_chk;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_syn;
  logic        out_corr;
  logic        out_unc;
  logic        key_shift;
  logic        key_bit;
  logic        unlocked;
  logic        lockout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sec_lock_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_chk    (in_chk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_syn   (out_syn),
    .out_corr  (out_corr),
    .out_unc   (out_unc),
    .key_shift (key_shift),
    .key_bit   (key_bit),
    .unlocked  (unlocked),
    .lockout   (lockout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Shift key bits first..last, indexed MSB first.
  task automatic shift_bits(input logic [15:0] k, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      key_shift = 1'b1;
      key_bit   = k[15-i];
      step();
    end
    key_shift = 1'b0;
    key_bit   = 1'b0;
  endtask

  // One word through an empty pipeline with out_ready high.
  task automatic xfer(input string tag, input logic [31:0] d, input logic [7:0] c,
                      input logic [31:0] ed, input logic [7:0] es,
                      input logic ec, input logic eu);
    in_data  = d;
    in_chk   = c;
    in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    check({tag, " valid after 1 edge"}, out_valid, 0);
    step();
    check({tag, " valid after 2 edges"}, out_valid, 1);
    check({tag, " data"}, out_data, ed);
    check({tag, " syn"}, out_syn, es);
    check({tag, " corr"}, out_corr, ec);
    check({tag, " unc"}, out_unc, eu);
    step();
  endtask

  logic [31:0] bp_d [8] = '{32'h1, 32'h2, 32'h4, 32'h8, 32'h10, 32'h20, 32'h40, 32'h80};
  logic [7:0]  bp_c [8] = '{8'h03, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A, 8'h0B, 8'h0C};

  initial begin
    int          sent, got, inflight, acc, del;
    logic        stalled, saw_full;
    logic [31:0] prev_d;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chk    = '0;
    out_ready = 1'b1;
    key_shift = 1'b0;
    key_bit   = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst out_syn", out_syn, 0);
    check("rst out_corr", out_corr, 0);
    check("rst out_unc", out_unc, 0);
    check("rst unlocked", unlocked, 0);
    check("rst lockout", lockout, 0);
    step();
    rst_n = 1'b1;
    step();

    // Clean word while locked: mask is KEY_VALUE replicated.
    xfer("locked clean", 32'h0, 8'h00, 32'hA5C3A5C3, 8'h00, 0, 0);

    // Unlock.
    shift_bits(16'hA5C3, 0, 14);
    check("unlock before last bit", unlocked, 0);
    shift_bits(16'hA5C3, 15, 15);
    check("unlock after 16 bits", unlocked, 1);
    check("unlock lockout", lockout, 0);

    xfer("data bit0 err", 32'h0, 8'h03, 32'h1, 8'h03, 1, 0);
    xfer("check bit7 err", 32'h0, 8'h80, 32'h0, 8'h80, 1, 0);
    xfer("uncorrectable 3F", 32'h0, 8'h3F, 32'h0, 8'h3F, 0, 1);
    xfer("clean d1", 32'h1, 8'h03, 32'h1, 8'h00, 0, 0);
    xfer("data bit31 err", 32'h8000_0000, 8'h00, 32'h0, 8'h26, 1, 0);
    xfer("uncorrectable 27", 32'h0, 8'h27, 32'h0, 8'h27, 0, 1);

    // Back-pressure: out_ready pattern 1,0,0 repeating, input always offered.
    sent     = 0;
    got      = 0;
    inflight = 0;
    saw_full = 1'b0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_data = bp_d[sent];
        in_chk  = bp_c[sent];
      end
      #1;
      check("bp in_ready", in_ready, !(inflight == 2 && !out_ready));
      if (!in_ready) saw_full = 1'b1;
      acc = (in_valid && in_ready) ? 1 : 0;
      del = (out_valid && out_ready) ? 1 : 0;
      if (del == 1) begin
        check("bp order", out_data, bp_d[got]);
        got++;
      end
      stalled = out_valid && !out_ready;
      prev_d  = out_data;
      step();
      sent     = sent + acc;
      inflight = inflight + acc - del;
      if (stalled) check("bp stable", {out_valid, out_data}, {1'b1, prev_d});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp all delivered", got, 8);
    check("bp in_ready fell", saw_full, 1);

    // Reset mid-key with a stalled word in stage 2.
    out_ready = 1'b0;
    in_data   = 32'h2;
    in_chk    = 8'h05;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    shift_bits(16'hA5C3, 0, 8);
    check("midkey word held", {out_valid, out_data}, {1'b1, 32'h2});
    check("midkey still unlocked", unlocked, 1);
    rst_n = 1'b0;
    #1;
    check("midkey rst out_valid", out_valid, 0);
    check("midkey rst out_data", out_data, 0);
    check("midkey rst unlocked", unlocked, 0);
    check("midkey rst in_ready", in_ready, 1);
    step();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    step();
    shift_bits(16'hA5C3, 0, 15);
    check("fresh key unlocks", unlocked, 1);

    // First wrong commit, with a word crossing S1->S2 on the commit edge.
    shift_bits(16'h0000, 0, 7);
    check("mid wrong key unlocked", unlocked, 1);
    shift_bits(16'h0000, 8, 13);
    in_data   = 32'h1;
    in_chk    = 8'h03;
    in_valid  = 1'b1;
    key_shift = 1'b1;
    key_bit   = 1'b0;
    step();
    step();
    key_shift = 1'b0;
    in_valid  = 1'b0;
    check("commit edge valid", out_valid, 1);
    check("commit edge pre-key mask", out_data, 32'h1);
    check("wrong1 unlocked", unlocked, 0);
    check("wrong1 lockout", lockout, 0);
    step();
    check("post-commit mask", out_data, 32'hA5C3A5C2);
    step();

    shift_bits(16'h0000, 0, 15);
    check("wrong2 lockout", lockout, 0);
    shift_bits(16'h0000, 0, 15);
    check("wrong3 lockout", lockout, 1);
    shift_bits(16'hA5C3, 0, 15);
    check("lockout ignores key", unlocked, 0);
    check("lockout sticky", lockout, 1);
    xfer("lockout clean", 32'h0, 8'h00, 32'hFFFFFFFF, 8'h00, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
